// File: rtl/npu_pkg.sv
// Shared definitions for the NPU datapath: pixel width, 3x3 window packing
// and the window generator's state encoding.
package npu_pkg;

    localparam int DATA_W   = 8;
    localparam int WIN_TAPS = 9;
    localparam int WIN_W    = WIN_TAPS * DATA_W;

    // Tap indices within a window; tap i sits at bits [(WIN_TAPS-1-i)*DATA_W +: DATA_W]
    localparam int TAP_OLDEST = 0;
    localparam int TAP_CENTER = 4;
    localparam int TAP_NEWEST = 8;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// Enable-gated delay line: dout is the value presented on din DEPTH enabled
// cycles ago. Contents are not cleared by reset; they only freeze while it is held.
module line_buffer #(
    parameter int DEPTH  = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Shift every entry one place toward the output when enabled
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Storage register; held unchanged while reset is asserted
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream to 3x3 window generator (valid convolution, stride 1).
// Two line buffers supply the rows above the incoming pixel; a 3x3 register
// window shifts left on every accepted pixel and is published once both
// window coordinates are at least 2.
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 10,
    parameter int IMG_H  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   pix_in,
    input  logic                pix_en,
    output logic [9*DATA_W-1:0] win_out,
    output logic                win_en,
    output logic                frame_done
);

    import npu_pkg::*;

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(1);

    logic [CW-1:0]         col_cnt_q, col_cnt_d;
    logic [RW-1:0]         row_cnt_q, row_cnt_d;
    win_state_t            state_q, state_d;
    logic [DATA_W-1:0]     win_q [WIN_TAPS];
    logic [DATA_W-1:0]     win_d [WIN_TAPS];
    logic [9*DATA_W-1:0]   win_out_q, win_out_d;
    logic                  win_en_q, win_en_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_W-1:0]     lb0_out;
    logic [DATA_W-1:0]     lb1_out;
    logic                  last_col;
    logic                  last_row;

    // lb0 yields the pixel one row above, lb1 the pixel two rows above
    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) lb0 (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .din   (pix_in),
        .dout  (lb0_out)
    );

    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) lb1 (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .din   (lb0_out),
        .dout  (lb1_out)
    );

    // Window shift, raster counters, fill/run state and output publication
    always_comb begin
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        state_d      = state_q;
        win_d        = win_q;
        win_out_d    = win_out_q;
        win_en_d     = 1'b0;
        frame_done_d = 1'b0;
        last_col     = (col_cnt_q == COL_LAST);
        last_row     = (row_cnt_q == ROW_LAST);

        if (pix_en) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2]          = lb1_out;
            win_d[5]          = lb0_out;
            win_d[TAP_NEWEST] = pix_in;

            if (state_q == S_RUN && col_cnt_q >= COL_FIRST_WIN) begin
                win_en_d     = 1'b1;
                frame_done_d = last_col && last_row;
                for (int i = 0; i < WIN_TAPS; i++) begin
                    win_out_d[(WIN_TAPS-1-i)*DATA_W +: DATA_W] = win_d[i];
                end
            end

            if (last_col) begin
                col_cnt_d = '0;
                row_cnt_d = last_row ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end

            case (state_q)
                S_FILL: if (last_col && row_cnt_q == ROW_FILL_LAST) state_d = S_RUN;
                S_RUN:  if (last_col && last_row) state_d = S_FILL;
                default: state_d = S_FILL;
            endcase
        end
    end

    // State registers with synchronous reset; line buffers are deliberately excluded
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            state_q      <= S_FILL;
            win_out_q    <= '0;
            win_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < WIN_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            state_q      <= state_d;
            win_out_q    <= win_out_d;
            win_en_q     <= win_en_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    assign win_out    = win_out_q;
    assign win_en     = win_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 4x4 instance for the small-frame
// scenarios and a default 10x10 instance for the full-size ramp frame.
module tb_conv_window_gen;

    logic        clk = 1'b0;

    logic        reset_s;
    logic [7:0]  pix_in_s;
    logic        pix_en_s;
    logic [71:0] win_out_s;
    logic        win_en_s;
    logic        frame_done_s;

    logic        reset_d;
    logic [7:0]  pix_in_d;
    logic        pix_en_d;
    logic [71:0] win_out_d;
    logic        win_en_d;
    logic        frame_done_d;

    int checks   = 0;
    int failures = 0;

    localparam logic [71:0] EXP_A [4] = '{
        72'h00_01_02_04_05_06_08_09_0A,
        72'h01_02_03_05_06_07_09_0A_0B,
        72'h04_05_06_08_09_0A_0C_0D_0E,
        72'h05_06_07_09_0A_0B_0D_0E_0F
    };
    localparam int EXP_ACC [4] = '{10, 11, 14, 15};
    localparam logic [71:0] FRAME2_OFS = {9{8'h10}};

    conv_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut_s (
        .clk        (clk),
        .reset      (reset_s),
        .pix_in     (pix_in_s),
        .pix_en     (pix_en_s),
        .win_out    (win_out_s),
        .win_en     (win_en_s),
        .frame_done (frame_done_s)
    );

    conv_window_gen dut_d (
        .clk        (clk),
        .reset      (reset_d),
        .pix_in     (pix_in_d),
        .pix_en     (pix_en_d),
        .win_out    (win_out_d),
        .win_en     (win_en_d),
        .frame_done (frame_done_d)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    int          cyc = 0;
    int          acc_cyc = -1;
    logic [7:0]  acc_val = '0;

    logic [71:0] mon_win_s [$];
    bit          mon_fd_s  [$];
    logic [7:0]  mon_acc_s [$];
    bit          mon_lat_s [$];
    int          stray_fd_s = 0;
    logic [71:0] mon_win_d [$];
    bit          mon_fd_d  [$];
    int          stray_fd_d = 0;

    // Track the edge index and value of the most recent accepted pixel on the 4x4 instance
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pix_en_s && !reset_s) begin
            acc_cyc <= cyc + 1;
            acc_val <= pix_in_s;
        end
    end

    // Record every window pulse, away from the active edge
    always @(negedge clk) begin
        if (win_en_s) begin
            mon_win_s.push_back(win_out_s);
            mon_fd_s.push_back(frame_done_s);
            mon_acc_s.push_back(acc_val);
            mon_lat_s.push_back(acc_cyc == cyc);
        end else if (frame_done_s) begin
            stray_fd_s++;
        end
        if (win_en_d) begin
            mon_win_d.push_back(win_out_d);
            mon_fd_d.push_back(frame_done_d);
        end else if (frame_done_d) begin
            stray_fd_d++;
        end
    end

    task automatic clear_mon();
        mon_win_s.delete();
        mon_fd_s.delete();
        mon_acc_s.delete();
        mon_lat_s.delete();
        mon_win_d.delete();
        mon_fd_d.delete();
        stray_fd_s = 0;
        stray_fd_d = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] v, input logic e);
        pix_in_s = v;
        pix_en_s = e;
        @(posedge clk);
        #1;
    endtask

    task automatic step_d(input logic [7:0] v, input logic e);
        pix_in_d = v;
        pix_en_d = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_s  = 1'b1;
        reset_d  = 1'b1;
        pix_in_s = '0;
        pix_in_d = '0;
        pix_en_s = 1'b0;
        pix_en_d = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pix_in_s = 8'(i * 37 + 5);
            pix_in_d = 8'(i * 53 + 9);
            pix_en_s = i[0];
            pix_en_d = ~i[0];
            @(negedge clk);
            checks += 6;
            if (win_out_s !== '0) begin failures++; $display("[TB] FAIL reset_win_out_s: got %h expected 0", win_out_s); end
            if (win_en_s !== 1'b0) begin failures++; $display("[TB] FAIL reset_win_en_s: got %b expected 0", win_en_s); end
            if (frame_done_s !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done_s: got %b expected 0", frame_done_s); end
            if (win_out_d !== '0) begin failures++; $display("[TB] FAIL reset_win_out_d: got %h expected 0", win_out_d); end
            if (win_en_d !== 1'b0) begin failures++; $display("[TB] FAIL reset_win_en_d: got %b expected 0", win_en_d); end
            if (frame_done_d !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done_d: got %b expected 0", frame_done_d); end
        end
        pix_en_s = 1'b0;
        pix_en_d = 1'b0;
        reset_s  = 1'b0;
        reset_d  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        clear_mon();
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0);
        checks++;
        if (mon_win_s.size() != 4) begin failures++; $display("[TB] FAIL basic_count: got %0d expected 4", mon_win_s.size()); end
        for (int k = 0; k < 4 && k < mon_win_s.size(); k++) begin
            checks += 4;
            if (mon_win_s[k] !== EXP_A[k]) begin failures++; $display("[TB] FAIL basic_win[%0d]: got %h expected %h", k, mon_win_s[k], EXP_A[k]); end
            if (mon_fd_s[k] !== (k == 3)) begin failures++; $display("[TB] FAIL basic_fd[%0d]: got %b expected %b", k, mon_fd_s[k], (k == 3)); end
            if (mon_acc_s[k] !== 8'(EXP_ACC[k])) begin failures++; $display("[TB] FAIL basic_src[%0d]: got %0d expected %0d", k, mon_acc_s[k], EXP_ACC[k]); end
            if (mon_lat_s[k] !== 1'b1) begin failures++; $display("[TB] FAIL basic_latency[%0d]: got late pulse expected 1 cycle", k); end
        end
        checks++;
        if (stray_fd_s != 0) begin failures++; $display("[TB] FAIL basic_stray_fd: got %0d expected 0", stray_fd_s); end
    endtask

    task automatic test_gapped();
        logic [71:0] hold_exp;
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i), 1'b1);
            applyStimulus(8'hEE, 1'b0);
            @(negedge clk);
            if (i >= 10) begin
                hold_exp = (i < 11) ? EXP_A[0] : (i < 14) ? EXP_A[1] : (i == 14) ? EXP_A[2] : EXP_A[3];
                checks += 2;
                if (win_out_s !== hold_exp) begin failures++; $display("[TB] FAIL gap_hold[%0d]: got %h expected %h", i, win_out_s, hold_exp); end
                if (win_en_s !== 1'b0) begin failures++; $display("[TB] FAIL gap_en[%0d]: got %b expected 0", i, win_en_s); end
            end
            applyStimulus(8'hEE, 1'b0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0);
        checks++;
        if (mon_win_s.size() != 4) begin failures++; $display("[TB] FAIL gap_count: got %0d expected 4", mon_win_s.size()); end
        for (int k = 0; k < 4 && k < mon_win_s.size(); k++) begin
            checks += 4;
            if (mon_win_s[k] !== EXP_A[k]) begin failures++; $display("[TB] FAIL gap_win[%0d]: got %h expected %h", k, mon_win_s[k], EXP_A[k]); end
            if (mon_fd_s[k] !== (k == 3)) begin failures++; $display("[TB] FAIL gap_fd[%0d]: got %b expected %b", k, mon_fd_s[k], (k == 3)); end
            if (mon_acc_s[k] !== 8'(EXP_ACC[k])) begin failures++; $display("[TB] FAIL gap_src[%0d]: got %0d expected %0d", k, mon_acc_s[k], EXP_ACC[k]); end
            if (mon_lat_s[k] !== 1'b1) begin failures++; $display("[TB] FAIL gap_latency[%0d]: got late pulse expected 1 cycle", k); end
        end
        checks++;
        if (stray_fd_s != 0) begin failures++; $display("[TB] FAIL gap_stray_fd: got %0d expected 0", stray_fd_s); end
    endtask

    task automatic test_back_to_back();
        logic [71:0] exp_win;
        int          fd_total;
        clear_mon();
        for (int i = 0; i < 32; i++) applyStimulus(8'(i), 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0);
        checks++;
        if (mon_win_s.size() != 8) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 8", mon_win_s.size()); end
        fd_total = 0;
        for (int k = 0; k < 8 && k < mon_win_s.size(); k++) begin
            exp_win = (k < 4) ? EXP_A[k] : EXP_A[k-4] + FRAME2_OFS;
            if (mon_fd_s[k]) fd_total++;
            checks += 2;
            if (mon_win_s[k] !== exp_win) begin failures++; $display("[TB] FAIL b2b_win[%0d]: got %h expected %h", k, mon_win_s[k], exp_win); end
            if (mon_fd_s[k] !== (k % 4 == 3)) begin failures++; $display("[TB] FAIL b2b_fd[%0d]: got %b expected %b", k, mon_fd_s[k], (k % 4 == 3)); end
        end
        checks++;
        if (fd_total + stray_fd_s != 2) begin failures++; $display("[TB] FAIL b2b_fd_total: got %0d expected 2", fd_total + stray_fd_s); end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        for (int i = 0; i < 7; i++) applyStimulus(8'(i + 8'h40), 1'b1);
        reset_s  = 1'b1;
        pix_in_s = 8'h77;
        pix_en_s = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            @(negedge clk);
            checks += 3;
            if (win_en_s !== 1'b0) begin failures++; $display("[TB] FAIL midrst_en[%0d]: got %b expected 0", r, win_en_s); end
            if (frame_done_s !== 1'b0) begin failures++; $display("[TB] FAIL midrst_fd[%0d]: got %b expected 0", r, frame_done_s); end
            if (win_out_s !== '0) begin failures++; $display("[TB] FAIL midrst_win[%0d]: got %h expected 0", r, win_out_s); end
        end
        reset_s  = 1'b0;
        pix_en_s = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0);
        checks++;
        if (mon_win_s.size() != 4) begin failures++; $display("[TB] FAIL midrst_count: got %0d expected 4", mon_win_s.size()); end
        for (int k = 0; k < 4 && k < mon_win_s.size(); k++) begin
            checks += 3;
            if (mon_win_s[k] !== EXP_A[k]) begin failures++; $display("[TB] FAIL midrst_win[%0d]: got %h expected %h", k, mon_win_s[k], EXP_A[k]); end
            if (mon_fd_s[k] !== (k == 3)) begin failures++; $display("[TB] FAIL midrst_fd[%0d]: got %b expected %b", k, mon_fd_s[k], (k == 3)); end
            if (mon_acc_s[k] !== 8'(EXP_ACC[k])) begin failures++; $display("[TB] FAIL midrst_src[%0d]: got %0d expected %0d", k, mon_acc_s[k], EXP_ACC[k]); end
        end
    endtask

    task automatic test_default_ramp();
        logic [71:0] exp_win;
        clear_mon();
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) step_d(8'(r * 16 + c), 1'b1);
        end
        for (int i = 0; i < 3; i++) step_d(8'h00, 1'b0);
        checks++;
        if (mon_win_d.size() != 64) begin failures++; $display("[TB] FAIL ramp_count: got %0d expected 64", mon_win_d.size()); end
        for (int k = 0; k < 64 && k < mon_win_d.size(); k++) begin
            for (int i = 0; i < 9; i++) begin
                exp_win[(8-i)*8 +: 8] = 8'((k / 8 + i / 3) * 16 + (k % 8 + i % 3));
            end
            checks += 3;
            if (mon_win_d[k][39:32] !== 8'((k / 8 + 1) * 16 + (k % 8 + 1))) begin failures++; $display("[TB] FAIL ramp_centre[%0d]: got %h expected %h", k, mon_win_d[k][39:32], 8'((k / 8 + 1) * 16 + (k % 8 + 1))); end
            if (mon_win_d[k] !== exp_win) begin failures++; $display("[TB] FAIL ramp_win[%0d]: got %h expected %h", k, mon_win_d[k], exp_win); end
            if (mon_fd_d[k] !== (k == 63)) begin failures++; $display("[TB] FAIL ramp_fd[%0d]: got %b expected %b", k, mon_fd_d[k], (k == 63)); end
        end
        checks++;
        if (stray_fd_d != 0) begin failures++; $display("[TB] FAIL ramp_stray_fd: got %0d expected 0", stray_fd_d); end
    endtask

    // Run the scenarios in sequence and report
    initial begin
        test_reset();
        test_basic_frame();
        test_gapped();
        test_back_to_back();
        test_reset_mid_frame();
        test_default_ramp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
